// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin N:1 AXI-Stream arbiter with zero-latency forwarding.
// Define STREAM_ARBITER_PACKET_LOCK_EN for packet-level locking; default is beat-level.
module stream_arbiter #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 in_valid,
    output logic [N-1:0]                 in_ready,
    input  logic [N*ID_WIDTH-1:0]        in_id,
    input  logic [N*DEST_WIDTH-1:0]      in_dest,
    input  logic [N*DATA_WIDTH-1:0]      in_data,
    input  logic [N*(DATA_WIDTH/8)-1:0]  in_strb,
    input  logic [N*(DATA_WIDTH/8)-1:0]  in_keep,
    input  logic [N-1:0]                 in_last,
    input  logic [N*USER_WIDTH-1:0]      in_user,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [DEST_WIDTH-1:0]        out_dest,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [DATA_WIDTH/8-1:0]      out_strb,
    output logic [DATA_WIDTH/8-1:0]      out_keep,
    output logic                         out_last,
    output logic [USER_WIDTH-1:0]        out_user,
    output logic [$clog2(N)-1:0]         grant,
    output logic                         locked
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int GW = $clog2(N);

    logic [ID_WIDTH-1:0]   id_a   [N];
    logic [DEST_WIDTH-1:0] dest_a [N];
    logic [DATA_WIDTH-1:0] data_a [N];
    logic [KW-1:0]         strb_a [N];
    logic [KW-1:0]         keep_a [N];
    logic [USER_WIDTH-1:0] user_a [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign id_a[i]   = in_id[i*ID_WIDTH +: ID_WIDTH];
        assign dest_a[i] = in_dest[i*DEST_WIDTH +: DEST_WIDTH];
        assign data_a[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign strb_a[i] = in_strb[i*KW +: KW];
        assign keep_a[i] = in_keep[i*KW +: KW];
        assign user_a[i] = in_user[i*USER_WIDTH +: USER_WIDTH];
    end

    logic [GW-1:0] last_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_sel;
    logic [GW-1:0] sel;
    logic          stall_q;
    logic          hold_lock;
    logic          hold;
    logic          accept;
    logic          last_upd;

    // Highest k assigned first so the nearest valid input after last wins.
    always_comb begin
        logic [GW-1:0] cand;
        cand   = '0;
        rr_sel = GW'((int'(last_q) + 1) % N);
        for (int k = N; k >= 1; k--) begin
            cand = GW'((int'(last_q) + k) % N);
            if (in_valid[cand]) rr_sel = cand;
        end
    end

`ifdef STREAM_ARBITER_PACKET_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && !out_last) state_d = LOCK;
            LOCK:    if (accept && out_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign hold_lock = (state_q == LOCK);
    assign last_upd  = out_last;
    assign locked    = (state_q == LOCK);
`else
    assign hold_lock = 1'b0;
    assign last_upd  = 1'b1;
    assign locked    = 1'b0;
`endif

    // A stalled beat keeps its grant so a newly valid input cannot retract it.
    assign hold   = hold_lock | stall_q;
    assign sel    = hold ? grant_q : rr_sel;
    assign grant  = rst ? '0 : sel;
    assign accept = out_valid & out_ready;

    assign out_valid = ~rst & in_valid[sel];
    assign out_id    = id_a[sel];
    assign out_dest  = dest_a[sel];
    assign out_data  = data_a[sel];
    assign out_strb  = strb_a[sel];
    assign out_keep  = keep_a[sel];
    assign out_last  = in_last[sel];
    assign out_user  = user_a[sel];

    always_comb begin
        in_ready = '0;
        if (!rst) in_ready[sel] = out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= GW'(N - 1);
            grant_q <= '0;
            stall_q <= 1'b0;
        end else begin
            grant_q <= sel;
            stall_q <= out_valid & ~out_ready;
            if (accept && last_upd) last_q <= sel;
        end
    end

endmodule
